fib_seq_gen: RTL and testbench
==============================

// Module: fib_seq_gen
// PURPOSE
//  Parametrised Fibonacci sequence generator. Successor to the fixed 6-bit free-running Fib FSM.
//  Adds programmable seeds, term count, a valid/ready output stream with backpressure,
//  overflow detection with stop/wrap modes, and abort.
//  Sits in State_Machines as a reusable sequence source for downstream datapath/display blocks.
// PARAMETERS
//  WIDTH  6  bit width of each term (aout, seeds, a/b registers)
//  CNT_W  8  width of num_terms and index
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  start      in   1      load seeds/count and begin; honoured only in IDLE, DONE or OVF
//  abort      in   1      synchronous; return to IDLE from any state
//  mode       in   1      0 = STOP on overflow, 1 = WRAP (truncate mod 2^WIDTH)
//  seed_a     in   WIDTH  term 0
//  seed_b     in   WIDTH  term 1
//  num_terms  in   CNT_W  number of terms to emit (0 allowed)
//  out_ready  in   1      downstream accepts aout when out_valid && out_ready
//  aout       out  WIDTH  current term
//  out_valid  out  1      aout holds a valid term
//  index      out  CNT_W  ordinal of current term (0-based)
//  done       out  1      level; high in DONE
//  overflow   out  1      sticky; cleared by reset, start or abort
//  state      out  2      IDLE=0, RUN=1, DONE=2, OVF=3
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; aout=0, out_valid=0, index=0, done=0, overflow=0.
//    Internal a, b and carry flag b_c are cleared.
//  - IDLE/DONE/OVF + start: latch a=seed_a, b=seed_b, b_c=0, n=num_terms; index=0; overflow=0.
//    If num_terms==0: DONE next edge, out_valid stays 0.
//    Otherwise: RUN next edge with out_valid=1, aout=seed_a. Latency: start edge -> first term 1 cycle.
//  - aout is always register a. Sum = a+b computed at WIDTH+1 bits; bit WIDTH is the carry.
//  - RUN, out_valid && !out_ready: aout, index and a/b all hold stable; no term is skipped.
//  - RUN, accept and index==n-1: go to DONE; out_valid=0, done=1 next edge; aout holds the last term.
//  - RUN, accept and index<n-1:
//    - STOP mode with b_c==1: go to OVF; out_valid=0, overflow=1. The overflowed term is never emitted.
//    - Otherwise: a<=b, b<=sum[WIDTH-1:0], b_c<=sum[WIDTH], index<=index+1.
//      In WRAP mode, overflow is set on the same edge the wrapped term (b_c==1) becomes aout.
//  - Carry is computed fresh on each add from truncated operands; no multi-bit overflow tracking.
//  - start while RUN is ignored. abort has priority over start and over accept.
//    abort: IDLE next edge; out_valid, done and overflow = 0; aout holds.
//  - seed_b is emitted unchecked; seeds are never flagged as overflow.
//  - index never wraps: n <= 2^CNT_W-1 bounds it.
// STRUCTURE
//  - fib_pkg: state encodings (ST_IDLE..ST_OVF), MODE_STOP/MODE_WRAP constants.
//  - Sub-module fib_term_reg: a/b/b_c register pair plus WIDTH+1 adder.
//    Controls: load, advance; outputs a, b_c. The top holds the FSM, index counter and flags.
// TESTING
//  1. WIDTH=6, seeds 0,1, num=10, ready=1:
//     aout 0,1,1,2,3,5,8,13,21,34 on 10 consecutive cycles; then done=1, state=2, out_valid=0.
//  2. STOP mode, seeds 0,1, num=20: emits 0..55 (11 terms).
//     Next edge state=3, overflow=1, out_valid=0; 89 is never shown.
//  3. WRAP mode, same stimulus: 12th term aout=25 with overflow=1 on that cycle;
//     13th=16, 14th=41; runs all 20 terms and ends in DONE with overflow still 1.
//  4. Backpressure: ready pattern 1,0,0,1,0,1...: aout/index stable while stalled.
//     Accepted sequence is identical to test 1 with no duplicates or gaps.
//  5. reset pulsed mid-RUN between clock edges: outputs 0 and state=0 before the next edge.
//     abort mid-RUN: IDLE next edge; start in the same cycle as abort is ignored.
//  6. num=0: DONE after 1 cycle, out_valid never 1.
//     num=1, seeds 7,9: single term 7, then DONE. start while RUN: sequence unaffected.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence generator: FSM state
// encodings and overflow-mode selectors.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_OVF  = 2'd3
  } fib_state_t;

  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

endpackage : fib_pkg

// File: rtl/fib_term_reg.sv
// Term register pair for the Fibonacci generator.
// a is the term currently presented and b is the next one. b_c is the carry
// produced when b was computed, i.e. it marks b as a wrapped (overflowed) term.
module fib_term_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  output logic [WIDTH-1:0] a,
  output logic             b_c
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             b_c_r;
  logic [WIDTH:0]   sum_s;

  // Add the two truncated terms one bit wider so the top bit is the carry.
  always_comb begin
    sum_s = {1'b0, a_r} + {1'b0, b_r};
  end

  // Load seeds on start, shift the pair forward on each accepted term, else hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      b_c_r <= 1'b0;
    end else if (load) begin
      a_r   <= seed_a;
      b_r   <= seed_b;
      b_c_r <= 1'b0;
    end else if (advance) begin
      a_r   <= b_r;
      b_r   <= sum_s[WIDTH-1:0];
      b_c_r <= sum_s[WIDTH];
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      b_c_r <= b_c_r;
    end
  end

  assign a   = a_r;
  assign b_c = b_c_r;

endmodule : fib_term_reg

// File: rtl/fib_seq_gen.sv
// Parametrised Fibonacci sequence generator with programmable seeds and term
// count, a valid/ready output stream, overflow stop/wrap modes and abort.
// The term arithmetic lives in fib_term_reg; this level owns the FSM,
// the term index and the status flags.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aout,
  output logic             out_valid,
  output logic [CNT_W-1:0] index,
  output logic             done,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  fib_state_t       state_r;
  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] index_r;
  logic             out_valid_r;
  logic             done_r;
  logic             overflow_r;

  logic [WIDTH-1:0] a_s;
  logic             b_c_s;
  logic             accept_s;
  logic             last_s;
  logic             stop_hit_s;
  logic             load_s;
  logic             advance_s;

  // Decode handshake and term-register controls; abort suppresses any load or advance.
  always_comb begin
    accept_s   = out_valid_r && out_ready;
    last_s     = (index_r == (n_r - CNT_ONE));
    stop_hit_s = (mode == MODE_STOP) && b_c_s;
    if (abort) begin
      load_s    = 1'b0;
      advance_s = 1'b0;
    end else if (state_r == ST_RUN) begin
      load_s    = 1'b0;
      advance_s = accept_s && !last_s && !stop_hit_s;
    end else begin
      load_s    = start;
      advance_s = 1'b0;
    end
  end

  fib_term_reg #(
    .WIDTH (WIDTH)
  ) u_term (
    .clock   (clock),
    .reset   (reset),
    .load    (load_s),
    .advance (advance_s),
    .seed_a  (seed_a),
    .seed_b  (seed_b),
    .a       (a_s),
    .b_c     (b_c_s)
  );

  // Sequencing FSM with registered status outputs, term count and index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      n_r         <= CNT_ZERO;
      index_r     <= CNT_ZERO;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (abort) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_OVF: begin
          if (start) begin
            n_r        <= num_terms;
            index_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
            if (num_terms == CNT_ZERO) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              state_r     <= ST_RUN;
              out_valid_r <= 1'b1;
              done_r      <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (last_s) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b0;
              done_r      <= 1'b1;
            end else if (stop_hit_s) begin
              // The wrapped term is withheld; stop with the flag raised.
              state_r     <= ST_OVF;
              out_valid_r <= 1'b0;
              overflow_r  <= 1'b1;
            end else begin
              index_r <= index_r + CNT_ONE;
              // In wrap mode the flag rises as the wrapped term reaches aout.
              if (b_c_s) begin
                overflow_r <= 1'b1;
              end else begin
                overflow_r <= overflow_r;
              end
            end
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign aout      = a_s;
  assign out_valid = out_valid_r;
  assign index     = index_r;
  assign done      = done_r;
  assign overflow  = overflow_r;
  assign state     = state_r;

endmodule : fib_seq_gen

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: a table of directed sequences with
// hand-computed end results, a behavioural term-list model for per-cycle
// checks, randomized backpressure/start noise, and reset/abort corner cases.
module tb_fib_seq_gen;
  import fib_pkg::*;

  localparam int WIDTH = 6;
  localparam int CNT_W = 8;
  localparam int MODV  = 64;

  logic             clock;
  logic             reset;
  logic             start;
  logic             abort;
  logic             mode;
  logic [WIDTH-1:0] seed_a;
  logic [WIDTH-1:0] seed_b;
  logic [CNT_W-1:0] num_terms;
  logic             out_ready;
  logic [WIDTH-1:0] aout;
  logic             out_valid;
  logic [CNT_W-1:0] index;
  logic             done;
  logic             overflow;
  logic [1:0]       state;

  int vectors;
  int miscompares;

  typedef struct {
    int sa;
    int sb;
    int num;
    int md;
    int cnt;
    int st;
    int ovf;
    int last;
  } vec_t;

  vec_t tbl[7];

  fib_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .seed_a    (seed_a),
    .seed_b    (seed_b),
    .num_terms (num_terms),
    .out_ready (out_ready),
    .aout      (aout),
    .out_valid (out_valid),
    .index     (index),
    .done      (done),
    .overflow  (overflow),
    .state     (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one sequence and checks it cycle by cycle against a term-list model.
  task automatic run_case(input vec_t v, input bit rnd_ready, input bit noise, input bit use_tbl);
    int terms[256];
    int ovf_at[256];
    int mcount;
    int mstate;
    int movf;
    int k;
    int cyc;
    int t;
    int s;
    bit of;
    // Model: term k is seed or (t[k-1]+t[k-2]) mod 2^W; a carry stops (STOP) or flags (WRAP).
    mcount = 0;
    movf   = 0;
    mstate = 2;
    for (int j = 0; j < v.num; j++) begin
      if (j == 0) begin
        t = v.sa; of = 1'b0;
      end else if (j == 1) begin
        t = v.sb; of = 1'b0;
      end else begin
        s = terms[j-1] + terms[j-2];
        t = s % MODV;
        of = (s >= MODV);
      end
      if (of && v.md == 0) begin
        mstate = 3;
        movf   = 1;
        break;
      end
      if (of) movf = 1;
      terms[j]  = t;
      ovf_at[j] = movf;
      mcount++;
    end

    @(negedge clock);
    mode      = v.md[0];
    seed_a    = v.sa[WIDTH-1:0];
    seed_b    = v.sb[WIDTH-1:0];
    num_terms = v.num[CNT_W-1:0];
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("first_valid", int'(out_valid), (v.num != 0) ? 1 : 0);
    chk("first_state", int'(state), (v.num != 0) ? 1 : 2);

    k   = 0;
    cyc = 0;
    while (state == 2'd1 && cyc < 400) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        seed_a = WIDTH'($urandom);
        seed_b = WIDTH'($urandom);
      end
      if (k >= mcount) begin
        chk("extra_term", k, mcount - 1);
      end else begin
        chk("run_valid", int'(out_valid), 1);
        chk("aout", int'(aout), terms[k]);
        chk("index", int'(index), k);
        chk("run_ovf", int'(overflow), ovf_at[k]);
      end
      if (out_ready && out_valid) k++;
      @(negedge clock);
      cyc++;
    end
    start  = 1'b0;
    seed_a = v.sa[WIDTH-1:0];
    seed_b = v.sb[WIDTH-1:0];
    if (cyc >= 400) chk("timeout", cyc, 0);
    if (!rnd_ready) chk("no_stall_cycles", cyc, mcount);
    chk("term_count", k, mcount);
    chk("end_state", int'(state), mstate);
    chk("end_done", int'(done), (mstate == 2) ? 1 : 0);
    chk("end_valid", int'(out_valid), 0);
    chk("end_ovf", int'(overflow), movf);
    chk("end_aout", int'(aout), (mcount > 0) ? terms[mcount-1] : v.sa);
    if (use_tbl) begin
      chk("tbl_count", k, v.cnt);
      chk("tbl_state", int'(state), v.st);
      chk("tbl_ovf", int'(overflow), v.ovf);
      chk("tbl_last", int'(aout), v.last);
    end
  endtask

  initial begin
    vec_t rv;
    int   prev;
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    mode      = 1'b0;
    seed_a    = 6'd0;
    seed_b    = 6'd0;
    num_terms = 8'd0;
    out_ready = 1'b1;

    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_aout", int'(aout), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_index", int'(index), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clock);
    reset = 1'b0;

    tbl[0] = '{0, 1, 10, 0, 10, 2, 0, 34};
    tbl[1] = '{0, 1, 20, 0, 11, 3, 1, 55};
    tbl[2] = '{0, 1, 20, 1, 20, 2, 1, 21};
    tbl[3] = '{0, 1, 0, 0, 0, 2, 0, 0};
    tbl[4] = '{7, 9, 1, 0, 1, 2, 0, 7};
    tbl[5] = '{63, 63, 5, 1, 5, 2, 1, 59};
    tbl[6] = '{63, 63, 5, 0, 2, 3, 1, 63};

    for (int i = 0; i < 7; i++) begin
      run_case(tbl[i], 1'b0, 1'b0, 1'b1);
      run_case(tbl[i], 1'b1, 1'b1, 1'b1);
    end

    for (int i = 0; i < 25; i++) begin
      rv.sa  = int'($urandom_range(0, MODV - 1));
      rv.sb  = int'($urandom_range(0, MODV - 1));
      rv.num = int'($urandom_range(0, 40));
      rv.md  = int'($urandom_range(0, 1));
      rv.cnt = 0; rv.st = 0; rv.ovf = 0; rv.last = 0;
      run_case(rv, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset between edges in the middle of a run.
    @(negedge clock);
    mode = 1'b0; seed_a = 6'd0; seed_b = 6'd1; num_terms = 8'd10;
    out_ready = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre_rst_index", int'(index), 4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_aout", int'(aout), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_index", int'(index), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_state", int'(state), 0);

    // Abort in WRAP mode after overflow is set; a same-cycle start is ignored.
    mode = 1'b1; seed_a = 6'd0; seed_b = 6'd1; num_terms = 8'd20;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (12) @(negedge clock);
    chk("pre_abort_index", int'(index), 12);
    chk("pre_abort_ovf", int'(overflow), 1);
    chk("pre_abort_aout", int'(aout), 16);
    prev   = int'(aout);
    abort  = 1'b1;
    start  = 1'b1;
    seed_a = 6'd5;
    @(negedge clock);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_state", int'(state), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_ovf", int'(overflow), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_aout_hold", int'(aout), prev);
    @(negedge clock);
    chk("abort_stays_idle", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fib_seq_gen
